// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: run controller for a programmable PAT_W-bit serial pattern
// detector. It arms on start, clears its history for one LOAD cycle, then
// shifts qualified bits in RUN and counts matches. A run ends on reaching a
// programmed target, or on abort. Overlapping and non-overlapping detection
// are both supported.
//
// Input qualification: a bit on `in` is consumed only on a rising clk edge
// where in_valid=1 and the controller is in RUN. There is no ready signal.
// The source must hold or re-present a bit if it needs that bit consumed
// outside RUN. Bits offered while the controller is not in RUN are dropped.
module seq_match_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             in_valid,
  input  logic             in,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  // The fill counter saturates at PAT_W, so it needs enough bits to hold PAT_W.
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_HIT = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q,   state_d;
  logic [PAT_W-1:0] hist_q,    hist_d;
  logic [FILL_W-1:0] fill_q,   fill_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             match_q,   match_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [PAT_W-1:0] pat_q,     pat_d;
  logic             ovl_q,     ovl_d;
  logic [CNT_W-1:0] tgt_q,     tgt_d;

  logic [PAT_W-1:0] cand;
  logic             hit;

  // Next-state, history shift, match detection and config latch.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    tgt_d   = tgt_q;
    cand    = {hist_q[PAT_W-2:0], in};
    hit     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Abort has no meaning here, so start always wins.
        if (start) begin
          pat_d   = cfg_pattern;
          ovl_d   = cfg_overlap;
          tgt_d   = cfg_target;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // An abort here leaves the previous count visible.
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          hist_d  = '0;
          fill_d  = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort takes priority, so a same-cycle hit is dropped.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          hit    = (fill_q >= FILL_HIT) && (cand == pat_q);
          hist_d = cand;
          if (fill_q != FILL_MAX) fill_d = fill_q + FILL_ONE;
          if (hit) begin
            match_d = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            // Without overlap, the matched bits must not seed the next match.
            if (!ovl_q) fill_d = '0;
            if ((tgt_q != '0) && (cnt_d == tgt_q)) state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers. Reset is asynchronous, active low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      tgt_q   <= tgt_d;
    end
  end

  assign busy      = busy_q;
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Bench for seq_match_ctrl.
// A mode/queue reference model tracks the expected outputs, and the bench
// compares them on every falling edge. Directed scenarios pin the model and
// the DUT with literal expectations. A randomized phase follows them.
module tb_seq_match_ctrl;
  localparam int PAT_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             done;
  logic [1:0]       state;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;

  seq_match_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .in_valid(in_valid), .in(in_bit),
    .busy(busy), .match(match), .match_cnt(match_cnt), .done(done), .state(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Mode numbers are the published state codes: 0 idle, 1 load, 2 run, 3 done.
  int   m_mode = 0;
  int   m_cnt = 0;
  bit   m_match = 1'b0;
  bit   m_bits[$];
  logic [PAT_W-1:0] m_pat = '0;
  bit   m_ovl = 1'b0;
  int   m_tgt = 0;

  initial begin
    bit hit;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_mode = 0; m_cnt = 0; m_match = 1'b0; m_bits.delete();
        m_pat = '0; m_ovl = 1'b0; m_tgt = 0;
      end else begin
        m_match = 1'b0;
        case (m_mode)
          0, 3: if (start) begin
            m_pat = cfg_pattern; m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
            m_mode = 1;
          end
          1: if (abort) m_mode = 0;
             else begin m_bits.delete(); m_cnt = 0; m_mode = 2; end
          default: if (abort) m_mode = 0;
            else if (in_valid) begin
              m_bits.push_back(in_bit);
              if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
              hit = (m_bits.size() == PAT_W);
              for (int i = 0; i < PAT_W; i++)
                if (hit && m_bits[i] != m_pat[PAT_W-1-i]) hit = 1'b0;
              if (hit) begin
                m_match = 1'b1;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                if (!m_ovl) m_bits.delete();
                if (m_tgt != 0 && m_cnt == m_tgt) m_mode = 3;
              end
            end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare + pulse monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (state !== 2'(m_mode) || busy !== (m_mode == 1 || m_mode == 2) ||
          done !== (m_mode == 3) || match !== m_match || match_cnt !== CNT_W'(m_cnt)) begin
        failures++;
        $display("FAIL cycle t=%0t got st=%0d busy=%0d done=%0d match=%0d cnt=%0d exp st=%0d busy=%0d done=%0d match=%0d cnt=%0d",
                 $time, state, busy, done, match, match_cnt,
                 m_mode, (m_mode == 1 || m_mode == 2), (m_mode == 3), m_match, m_cnt);
      end
      if (match === 1'b1) pulse_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_bit = 1'($urandom);
    end
  endtask

  // Start a run. On return the DUT is in LOAD, and the next driven bit is the first one sampled in RUN.
  task automatic do_start(input logic [PAT_W-1:0] pat, input bit ovl, input int tgt);
    @(negedge clk);
    start = 1'b1; abort = 1'b0; in_valid = 1'b0;
    cfg_pattern = pat; cfg_overlap = ovl; cfg_target = CNT_W'(tgt);
    @(negedge clk);
    start = 1'b0;
    // Scramble the config so the latched copy is what counts.
    cfg_pattern = ~pat; cfg_overlap = ~ovl; cfg_target = CNT_W'(tgt + 1);
  endtask

  task automatic send(input bit b);
    @(negedge clk);
    start = 1'b0; abort = 1'b0; in_valid = 1'b1; in_bit = b;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i]);
  endtask

  task automatic stop_run();
    @(negedge clk);
    abort = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_state", state, 0); chk("rst_busy", busy, 0); chk("rst_cnt", match_cnt, 0);
    chk("rst_done", done, 0); chk("rst_match", match, 0);
    @(negedge clk) rst = 1'b1;

    // Overlapping, run-forever: 1001001 gives two matches.
    p0 = pulse_cnt;
    do_start(4'b1001, 1'b1, 0);
    send_bits(16'b1001001, 7); idle(2); #2;
    chk("ovl_cnt", match_cnt, 2); chk("ovl_pulses", pulse_cnt - p0, 2);
    chk("ovl_busy", busy, 1); chk("ovl_done", done, 0);

    // Non-overlapping: the trailing 001 must not match.
    stop_run(); p0 = pulse_cnt;
    do_start(4'b1001, 1'b0, 0);
    send_bits(16'b1001001, 7); idle(2); #2;
    chk("novl_cnt", match_cnt, 1); chk("novl_pulses", pulse_cnt - p0, 1);

    // Target 2 reaches DONE and then ignores further bits.
    stop_run(); p0 = pulse_cnt;
    do_start(4'b1001, 1'b1, 2);
    send_bits(16'b1001001, 7); idle(2); #2;
    chk("tgt_done", done, 1); chk("tgt_busy", busy, 0);
    chk("tgt_state", state, 3); chk("tgt_cnt", match_cnt, 2);
    send_bits(16'b1001, 4); idle(2); #2;
    chk("tgt_hold_cnt", match_cnt, 2); chk("tgt_pulses", pulse_cnt - p0, 2);

    // Gaps carrying junk data neither shift nor match. Start directly from DONE.
    p0 = pulse_cnt;
    do_start(4'b1001, 1'b1, 0);
    for (int i = 3; i >= 0; i--) begin
      send(i == 3 || i == 0);
      @(negedge clk); in_valid = 1'b0; in_bit = 1'($urandom);
    end
    idle(2); #2;
    chk("gap_cnt", match_cnt, 1); chk("gap_pulses", pulse_cnt - p0, 1);

    // An abort on the same cycle as the last pattern bit drops the hit.
    stop_run(); p0 = pulse_cnt;
    do_start(4'b1001, 1'b1, 0);
    send_bits(16'b100, 3);
    @(negedge clk); in_valid = 1'b1; in_bit = 1'b1; abort = 1'b1;
    @(negedge clk); abort = 1'b0; in_valid = 1'b0;
    idle(1); #2;
    chk("abort_state", state, 0); chk("abort_cnt", match_cnt, 0);
    chk("abort_done", done, 0); chk("abort_pulses", pulse_cnt - p0, 0);
    do_start(4'b1001, 1'b1, 0); #2;
    chk("restart_load", state, 1);
    @(negedge clk); #2;
    chk("restart_run", state, 2); chk("restart_cnt", match_cnt, 0);

    // An abort keeps the pre-abort count (1) even though a second hit arrives in the same cycle.
    send_bits(16'b1001, 4); send_bits(16'b00, 2);
    @(negedge clk); in_valid = 1'b1; in_bit = 1'b1; abort = 1'b1;
    idle(2); #2;
    chk("abort_keep_cnt", match_cnt, 1); chk("abort_keep_state", state, 0);

    // Asynchronous reset in the middle of a run.
    do_start(4'b1001, 1'b1, 0);
    send_bits(16'b1001, 4); idle(2); #2;
    chk("pre_rst_cnt", match_cnt, 1);
    @(negedge clk); #1 rst = 1'b0; #1;
    chk("arst_cnt", match_cnt, 0); chk("arst_busy", busy, 0);
    chk("arst_state", state, 0); chk("arst_done", done, 0);
    @(negedge clk) rst = 1'b1;
    idle(1); #2;
    chk("post_rst_state", state, 0);
    p0 = pulse_cnt;
    do_start(4'b1001, 1'b1, 0);
    send_bits(16'b1001, 4); idle(2); #2;
    chk("rearm_cnt", match_cnt, 1); chk("rearm_pulses", pulse_cnt - p0, 1);

    // Randomized phase: the model tracks everything, including occasional resets.
    repeat (4000) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 299) != 0);
      start       = ($urandom_range(0, 19) == 0);
      abort       = ($urandom_range(0, 39) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_bit      = 1'($urandom);
      cfg_pattern = PAT_W'($urandom_range(0, (1 << PAT_W) - 1));
      cfg_overlap = 1'($urandom);
      cfg_target  = CNT_W'($urandom_range(0, 4));
    end
    @(negedge clk) rst = 1'b1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
